// File: rtl/z88_mem_sched.sv
// Slot scheduler for the shared external RAM/ROM port: alternates LCD and Z80 slots of
// CLK_DIV clocks each and runs at most one read/write access per slot.
module z88_mem_sched #(
   parameter int CLK_DIV = 4,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        clk_ena,
   output logic        bus_ph,
   input  logic        lcd_rden,
   input  logic [21:0] lcd_addr,
   output logic        lcd_vld,
   output logic [7:0]  lcd_rdata,
   input  logic        z80_req,
   input  logic        z80_we,
   input  logic [21:0] z80_addr,
   input  logic [7:0]  z80_wdata,
   output logic        z80_ack,
   output logic [7:0]  z80_rdata,
   output logic [21:0] mem_addr,
   output logic        mem_ce_n,
   output logic        mem_oe_n,
   output logic        mem_we_n,
   output logic [7:0]  mem_wdata,
   output logic        mem_wdata_oe,
   input  logic [7:0]  mem_rdata
);

   localparam int            TW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_SMP  = TW'(MEM_LAT);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] t_q;
   logic          bus_ph_q;
   logic          acc_z80_q;
   logic          acc_wr_q;
   logic          slot_end;
   logic          launch_lcd;
   logic          launch_z80;
   logic          launch;
   logic          launch_wr;
   logic          we_on;
   logic          release_acc;

   // Slot timebase: t runs 0..CLK_DIV-1, owner flips on the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_q      <= '0;
         bus_ph_q <= 1'b0;
      end else begin
         t_q <= slot_end ? '0 : t_q + 1'b1;
         if (slot_end) bus_ph_q <= ~bus_ph_q;
      end
   end

   assign slot_end = (t_q == T_LAST);
   assign clk_ena  = slot_end;
   assign bus_ph   = bus_ph_q;

   // Requests are sampled on the edge that opens a slot, so strobes are live during t=0.
   // bus_ph_q is still the owner of the closing slot here.
   assign launch_lcd = slot_end &  bus_ph_q & lcd_rden;
   assign launch_z80 = slot_end & ~bus_ph_q & z80_req;
   assign launch     = (state_q != S_ACCESS) & (launch_lcd | launch_z80);
   assign launch_wr  = launch_z80 & z80_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // DONE may coincide with t=CLK_DIV-1 when MEM_LAT=CLK_DIV-2, so it can relaunch directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (launch) state_d = S_ACCESS;
         S_ACCESS: if (t_q == T_SMP) state_d = S_DONE;
         S_DONE:   state_d = launch ? S_ACCESS : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lcd_vld     = 1'b0;
      z80_ack     = 1'b0;
      we_on       = 1'b0;
      release_acc = 1'b0;
      case (state_q)
         S_ACCESS: begin
            we_on       = acc_wr_q & (t_q == '0);
            release_acc = (t_q == T_SMP);
         end
         S_DONE: begin
            lcd_vld = ~acc_z80_q;
            z80_ack =  acc_z80_q;
         end
         default: ;
      endcase
   end

   // Memory-side registers; response data lands on the same edge the response pulse rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_z80_q    <= 1'b0;
         acc_wr_q     <= 1'b0;
         mem_addr     <= '0;
         mem_ce_n     <= 1'b1;
         mem_oe_n     <= 1'b1;
         mem_we_n     <= 1'b1;
         mem_wdata    <= '0;
         mem_wdata_oe <= 1'b0;
         lcd_rdata    <= '0;
         z80_rdata    <= '0;
      end else begin
         if (launch) begin
            acc_z80_q <= launch_z80;
            acc_wr_q  <= launch_wr;
            mem_addr  <= launch_z80 ? z80_addr : lcd_addr;
            mem_ce_n  <= 1'b0;
            mem_oe_n  <= launch_wr;
            if (launch_wr) begin
               mem_wdata    <= z80_wdata;
               mem_wdata_oe <= 1'b1;
            end
         end
         if (we_on) mem_we_n <= 1'b0;
         if (release_acc) begin
            mem_ce_n     <= 1'b1;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            mem_wdata_oe <= 1'b0;
            if (!acc_wr_q) begin
               if (acc_z80_q) z80_rdata <= mem_rdata;
               else           lcd_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_z88_mem_sched.sv
// Bench for z88_mem_sched: directed slot scenarios plus random LCD/Z80 traffic checked
// against a slot-schedule model and a behavioural memory.
module tb_z88_mem_sched;
   localparam int CD = 4;
   localparam int ML = 2;
   localparam int NR = 480;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        clk_ena, bus_ph, lcd_vld, z80_ack;
   logic        lcd_rden = 1'b0, z80_req = 1'b0, z80_we = 1'b0;
   logic [21:0] lcd_addr = '0, z80_addr = '0, mem_addr;
   logic [7:0]  z80_wdata = '0, lcd_rdata, z80_rdata, mem_wdata, mem_rdata = '0;
   logic        mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe;

   z88_mem_sched #(.CLK_DIV(CD), .MEM_LAT(ML)) dut (
      .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .bus_ph(bus_ph),
      .lcd_rden(lcd_rden), .lcd_addr(lcd_addr), .lcd_vld(lcd_vld), .lcd_rdata(lcd_rdata),
      .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr), .z80_wdata(z80_wdata),
      .z80_ack(z80_ack), .z80_rdata(z80_rdata), .mem_addr(mem_addr), .mem_ce_n(mem_ce_n),
      .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_wdata(mem_wdata),
      .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   int unsigned cyc = 0, base = 0;
   always @(posedge clk) cyc++;

   int nvec = 0, nerr = 0;

   // Behavioural SRAM on the pins: unwritten locations read a fixed address hash.
   logic [7:0] dev_mem [logic [21:0]];
   function automatic logic [7:0] dflt(input logic [21:0] a);
      return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
   endfunction
   always @(negedge clk) begin
      if (!mem_ce_n && !mem_we_n) dev_mem[mem_addr] = mem_wdata;
      if (!mem_ce_n && !mem_oe_n)
         mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
      else
         mem_rdata = 8'hEE;
   end

   function automatic int cc();
      return int'(cyc - base);
   endfunction
   function automatic int ct();
      return cc() % CD;
   endfunction
   function automatic int cph();
      return (cc() / CD) % 2;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int ph, input int t);
      do tick(); while (!(cph() == ph && ct() == t));
   endtask

   task automatic test_reset();
      tick(); tick();
      nvec++;
      if ({clk_ena, bus_ph, lcd_vld, z80_ack, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe} !== 8'b0000_1110) begin
         nerr++; $display("FAIL reset_ctl: got %b exp 00001110",
            {clk_ena, bus_ph, lcd_vld, z80_ack, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe});
      end
      nvec++;
      if ({mem_addr, mem_wdata, lcd_rdata, z80_rdata} !== '0) begin
         nerr++; $display("FAIL reset_data: got addr %h wd %h lrd %h zrd %h exp 0",
            mem_addr, mem_wdata, lcd_rdata, z80_rdata);
      end
      rst_n = 1'b1; base = cyc;
      z80_req = 1'b1; z80_we = 1'b1; z80_addr = 22'h2AAAAA; z80_wdata = 8'hC3;
      goto(1, 1);
      nvec++;
      if ({mem_we_n, mem_wdata_oe} !== 2'b01) begin
         nerr++; $display("FAIL reset_pre_write: got we_n/oe %b exp 01", {mem_we_n, mem_wdata_oe});
      end
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe} !== 4'b1110) begin
         nerr++; $display("FAIL reset_async_strobes: got %b exp 1110",
            {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe});
      end
      nvec++;
      if ({mem_addr, mem_wdata} !== '0) begin
         nerr++; $display("FAIL reset_async_data: got addr %h wd %h exp 0", mem_addr, mem_wdata);
      end
      z80_req = 1'b0; z80_we = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; base = cyc;
      for (int i = 0; i < CD; i++) begin
         nvec++;
         if ({bus_ph, clk_ena} !== {1'b0, (i == CD - 1)}) begin
            nerr++; $display("FAIL reset_first_slot clk %0d: got ph/ena %b exp %b", i,
               {bus_ph, clk_ena}, {1'b0, (i == CD - 1)});
         end
         tick();
      end
   endtask

   task automatic test_timebase();
      for (int i = 0; i < 64; i++) begin
         nvec++;
         if ({clk_ena, bus_ph} !== {(ct() == CD - 1), (cph() == 1)}) begin
            nerr++; $display("FAIL timebase cyc %0d: got ena/ph %b exp %b", cc(),
               {clk_ena, bus_ph}, {(ct() == CD - 1), (cph() == 1)});
         end
         tick();
      end
   endtask

   task automatic test_lcd_read();
      dev_mem[22'h0C0123] = 8'hA5;
      goto(1, 3);
      lcd_rden = 1'b1; lcd_addr = 22'h0C0123;
      tick();
      nvec++;
      if ({mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe} !== {22'h0C0123, 4'b0010}) begin
         nerr++; $display("FAIL lcd_t0: got addr %h ctl %b exp 0c0123 0010", mem_addr,
            {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe});
      end
      lcd_rden = 1'b0; lcd_addr = 22'h3FFFFF;
      tick(); tick();
      nvec++;
      if (lcd_vld !== 1'b0) begin
         nerr++; $display("FAIL lcd_t2_vld: got %b exp 0", lcd_vld);
      end
      tick();
      nvec++;
      if ({lcd_vld, z80_ack, mem_ce_n, lcd_rdata} !== {3'b101, 8'hA5}) begin
         nerr++; $display("FAIL lcd_t3: got vld %b ack %b ce_n %b data %h exp 1 0 1 a5",
            lcd_vld, z80_ack, mem_ce_n, lcd_rdata);
      end
      tick();
      nvec++;
      if ({lcd_vld, mem_ce_n, lcd_rdata} !== {2'b01, 8'hA5}) begin
         nerr++; $display("FAIL lcd_hold: got vld %b ce_n %b data %h exp 0 1 a5",
            lcd_vld, mem_ce_n, lcd_rdata);
      end
   endtask

   task automatic test_z80_write();
      z80_req = 1'b1; z80_we = 1'b1; z80_addr = 22'h200010; z80_wdata = 8'h3C;
      goto(1, 0);
      nvec++;
      if ({mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe} !== {22'h200010, 8'h3C, 4'b0111}) begin
         nerr++; $display("FAIL z80w_t0: got addr %h wd %h ctl %b exp 200010 3c 0111",
            mem_addr, mem_wdata, {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe});
      end
      for (int t = 1; t <= ML; t++) begin
         tick();
         nvec++;
         if ({mem_ce_n, mem_we_n, mem_wdata_oe, mem_wdata, z80_ack} !== {3'b001, 8'h3C, 1'b0}) begin
            nerr++; $display("FAIL z80w_t%0d: got ce/we/oe %b wd %h ack %b exp 001 3c 0", t,
               {mem_ce_n, mem_we_n, mem_wdata_oe}, mem_wdata, z80_ack);
         end
      end
      tick();
      nvec++;
      if ({z80_ack, lcd_vld, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, z80_rdata} !== {6'b101110, 8'h00}) begin
         nerr++; $display("FAIL z80w_ack: got ack %b vld %b ctl %b rdata %h exp 1 0 1110 00",
            z80_ack, lcd_vld, {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe}, z80_rdata);
      end
      z80_req = 1'b0; z80_we = 1'b0;
      nvec++;
      if (!dev_mem.exists(22'h200010) || dev_mem[22'h200010] !== 8'h3C) begin
         nerr++; $display("FAIL z80w_mem: location 200010 not written with 3c");
      end
      tick();
      nvec++;
      if (z80_ack !== 1'b0) begin
         nerr++; $display("FAIL z80w_ack_pulse: got %b exp 0", z80_ack);
      end
   endtask

   task automatic test_contention();
      dev_mem[22'h000005] = 8'h77;
      goto(1, 3);
      lcd_rden = 1'b1; lcd_addr = 22'h0C0200;
      z80_req = 1'b1; z80_we = 1'b0; z80_addr = 22'h000005;
      tick();
      nvec++;
      if ({mem_addr, mem_ce_n, mem_oe_n} !== {22'h0C0200, 2'b00}) begin
         nerr++; $display("FAIL cont_lcd_first: got addr %h ce/oe %b exp 0c0200 00",
            mem_addr, {mem_ce_n, mem_oe_n});
      end
      lcd_rden = 1'b0;
      tick(); tick();
      nvec++;
      if (mem_addr !== 22'h0C0200) begin
         nerr++; $display("FAIL cont_single_access: got addr %h exp 0c0200", mem_addr);
      end
      tick();
      nvec++;
      if ({lcd_vld, z80_ack, lcd_rdata} !== {2'b10, dflt(22'h0C0200)}) begin
         nerr++; $display("FAIL cont_lcd_vld: got vld %b ack %b data %h exp 1 0 %h",
            lcd_vld, z80_ack, lcd_rdata, dflt(22'h0C0200));
      end
      tick();
      nvec++;
      if ({mem_addr, mem_ce_n, mem_oe_n} !== {22'h000005, 2'b00}) begin
         nerr++; $display("FAIL cont_z80_slot: got addr %h ce/oe %b exp 000005 00",
            mem_addr, {mem_ce_n, mem_oe_n});
      end
      tick(); tick(); tick();
      nvec++;
      if ({z80_ack, lcd_vld, z80_rdata} !== {2'b10, 8'h77}) begin
         nerr++; $display("FAIL cont_z80_ack: got ack %b vld %b data %h exp 1 0 77",
            z80_ack, lcd_vld, z80_rdata);
      end
      z80_req = 1'b0;
      tick();
   endtask

   task automatic test_late_req();
      int n = 0;
      bit early = 1'b0;
      goto(1, 1);
      z80_req = 1'b1; z80_we = 1'b0; z80_addr = 22'h3FFFFF;
      while (z80_ack !== 1'b1 && n < 20) begin
         tick(); n++;
         if (n < 7 && !mem_ce_n) early = 1'b1;
      end
      // Raised at t=1: 7 clks to the next Z80 slot start, then MEM_LAT+1 to the ack.
      nvec++;
      if (n != 7 + ML + 1 || early) begin
         nerr++; $display("FAIL late_req_latency: got %0d clks early_launch %b exp %0d 0",
            n, early, 7 + ML + 1);
      end
      nvec++;
      if (z80_rdata !== dflt(22'h3FFFFF)) begin
         nerr++; $display("FAIL late_req_data: got %h exp %h", z80_rdata, dflt(22'h3FFFFF));
      end
      z80_req = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [5:0]  e_ctl [NR+8];
      logic [21:0] e_addr [NR+8];
      bit          e_av [NR+8], e_wv [NR+8], e_zrd [NR+8];
      logic [7:0]  e_wd [NR+8], e_dat [NR+8];
      logic [7:0]  mdl [logic [21:0]];
      logic [7:0]  held_l = 8'h00, held_z = 8'h00;
      bit          zbusy = 1'b0;
      for (int i = 0; i < NR + 8; i++) begin
         e_ctl[i] = 6'b111000; e_av[i] = 1'b0; e_wv[i] = 1'b0; e_zrd[i] = 1'b0;
         e_addr[i] = '0; e_wd[i] = '0; e_dat[i] = '0;
      end
      lcd_rden = 1'b0; z80_req = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; base = cyc;
      for (int c = 0; c < NR; c++) begin
         nvec++;
         if ({mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, lcd_vld, z80_ack, clk_ena, bus_ph} !==
             {e_ctl[c], (c % CD == CD - 1), ((c / CD) % 2 == 1)}) begin
            nerr++; $display("FAIL rand_ctl cyc %0d: got %b exp %b", c,
               {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, lcd_vld, z80_ack, clk_ena, bus_ph},
               {e_ctl[c], (c % CD == CD - 1), ((c / CD) % 2 == 1)});
         end
         if (e_av[c]) begin
            nvec++;
            if (mem_addr !== e_addr[c] || (e_wv[c] && mem_wdata !== e_wd[c])) begin
               nerr++; $display("FAIL rand_bus cyc %0d: got addr %h wd %h exp %h %h", c,
                  mem_addr, mem_wdata, e_addr[c], e_wd[c]);
            end
         end
         if (e_ctl[c][1]) held_l = e_dat[c];
         if (e_zrd[c])    held_z = e_dat[c];
         nvec++;
         if ({lcd_rdata, z80_rdata} !== {held_l, held_z}) begin
            nerr++; $display("FAIL rand_rdata cyc %0d: got lcd %h z80 %h exp %h %h", c,
               lcd_rdata, z80_rdata, held_l, held_z);
         end
         if (e_ctl[c][0]) begin
            zbusy = 1'b0; z80_req = 1'b0;
         end
         lcd_rden = 1'($urandom_range(0, 1));
         lcd_addr = {6'h3E, 16'($urandom)};
         if (!zbusy && $urandom_range(0, 2) == 0) begin
            zbusy = 1'b1; z80_req = 1'b1;
            z80_we = 1'($urandom_range(0, 1));
            z80_addr = 22'h000100 + 22'($urandom_range(0, 15));
            z80_wdata = 8'($urandom);
         end
         // Schedule model: the owner of the slot that opens on this edge gets it, if asking.
         if (c % CD == CD - 1) begin
            int s = c + 1;
            bit zs = ((s / CD) % 2 == 1);
            bit go = zs ? z80_req : lcd_rden;
            bit wr = zs & z80_we;
            logic [21:0] a = zs ? z80_addr : lcd_addr;
            if (go) begin
               for (int i = s; i <= s + ML; i++) begin
                  e_ctl[i][5] = 1'b0;
                  if (wr) e_ctl[i][2] = 1'b1; else e_ctl[i][4] = 1'b0;
                  if (wr && i > s) e_ctl[i][3] = 1'b0;
                  e_av[i] = 1'b1; e_addr[i] = a;
                  e_wv[i] = wr; e_wd[i] = z80_wdata;
               end
               if (zs) e_ctl[s + ML + 1][0] = 1'b1; else e_ctl[s + ML + 1][1] = 1'b1;
               if (wr) mdl[a] = z80_wdata;
               else begin
                  e_dat[s + ML + 1] = mdl.exists(a) ? mdl[a] : dflt(a);
                  e_zrd[s + ML + 1] = zs;
               end
            end
         end
         tick();
      end
      lcd_rden = 1'b0; z80_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_timebase();
      test_lcd_read();
      test_z80_write();
      test_contention();
      test_late_req();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
